// File: rtl/mips_cpu_ifetch.sv
// rtl/mips_cpu_ifetch.sv - MIPS instruction fetch stage with a single-outstanding-read bus master
//
// Purpose:
//   Fetches one 32-bit instruction at a time from a little-endian memory bus
//   and presents it byte-swapped (big-endian order) to decode. A fetch of
//   address 0 halts the stage; a misaligned fetch faults it. Both conditions
//   are sticky until rst.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   pc, fetch_req     fetch address and request from the PC stage
//   stall             decode not ready: hold the current instruction
//   flush             redirect: discard any pending or held instruction
//   mem_*             bus master (address, read strobe, byte enables,
//                     waitrequest, readdata)
//   instr, instr_pc   fetched instruction and the address it came from
//   instr_valid       instr holds an unconsumed instruction
//   busy              a bus read is outstanding; fetch_req is ignored
//   halted, fault     sticky stop indications

module mips_cpu_ifetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_req,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {IDLE, REQ, VALID, DRAIN, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] mem_address_n, instr_n, instr_pc_n;
  logic        mem_read_n, instr_valid_n, halted_n, fault_n;
  logic        accept;

  always_comb begin
    state_n       = state;
    mem_address_n = mem_address;
    mem_read_n    = mem_read;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    halted_n      = halted;
    fault_n       = fault;

    // A new fetch can start from IDLE, or straight out of VALID when decode
    // consumes the held instruction in the same cycle. flush always wins.
    accept = fetch_req && !flush &&
             ((state == IDLE) || ((state == VALID) && !stall));

    case (state)
      IDLE: ;
      REQ: begin
        if (!mem_waitrequest) begin
          mem_read_n = 1'b0;
          if (flush) begin
            state_n = IDLE;
          end else begin
            instr_n       = {mem_readdata[7:0], mem_readdata[15:8],
                             mem_readdata[23:16], mem_readdata[31:24]};
            instr_valid_n = 1'b1;
            state_n       = VALID;
          end
        end else if (flush) begin
          // The bus read cannot be withdrawn; let it complete and drop it.
          state_n = DRAIN;
        end
      end
      VALID: begin
        if (flush || !stall) begin
          instr_valid_n = 1'b0;
          state_n       = IDLE;
        end
      end
      DRAIN: begin
        if (!mem_waitrequest) begin
          mem_read_n = 1'b0;
          state_n    = IDLE;
        end
      end
      HALT: ;
      default: state_n = IDLE;
    endcase

    // Launch overrides the IDLE fallback chosen above for a consumed VALID.
    if (accept) begin
      if (pc == 32'd0) begin
        halted_n = 1'b1;
        state_n  = HALT;
      end else if (pc[1:0] != 2'b00) begin
        fault_n = 1'b1;
        state_n = HALT;
      end else begin
        mem_address_n = pc;
        instr_pc_n    = pc;
        mem_read_n    = 1'b1;
        state_n       = REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_address <= 32'd0;
      mem_read    <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      mem_address <= mem_address_n;
      mem_read    <= mem_read_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      halted      <= halted_n;
      fault       <= fault_n;
    end
  end

  assign mem_byteenable = mem_read ? 4'b1111 : 4'b0000;
  assign busy           = (state == REQ) || (state == DRAIN);

endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// tb/tb_mips_cpu_ifetch.sv - self-checking bench for mips_cpu_ifetch
module tb_mips_cpu_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_req, stall, flush;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, busy, halted, fault;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mips_cpu_ifetch dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req), .stall(stall),
    .flush(flush), .mem_address(mem_address), .mem_read(mem_read),
    .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .busy(busy), .halted(halted), .fault(fault)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] x);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++)
      r = r | (((x >> (8 * i)) & 32'hFF) << (8 * (3 - i)));
    return r;
  endfunction

  // Transaction-level model: a read is either live, being discarded, or
  // absent; an instruction is either held or not; the stage is stopped or not.
  logic        m_read, m_discard, m_have, m_stop, m_halted, m_fault;
  logic [31:0] m_addr, m_ipc, m_instr;

  always @(posedge clk) begin
    if (rst) begin
      m_read <= 0; m_discard <= 0; m_have <= 0; m_stop <= 0;
      m_halted <= 0; m_fault <= 0; m_addr <= 0; m_ipc <= 0; m_instr <= 0;
    end else if (m_stop) begin
    end else if (m_read || m_discard) begin
      if (!mem_waitrequest) begin
        m_read <= 0; m_discard <= 0;
        if (m_read && !flush) begin
          m_instr <= bswap(mem_readdata);
          m_have  <= 1;
        end
      end else if (flush && m_read) begin
        m_read <= 0; m_discard <= 1;
      end
    end else if (m_have && flush) begin
      m_have <= 0;
    end else if (!(m_have && stall)) begin
      m_have <= 0;
      if (fetch_req && !flush) begin
        if (pc == 0) begin
          m_halted <= 1; m_stop <= 1;
        end else if (pc % 4 != 0) begin
          m_fault <= 1; m_stop <= 1;
        end else begin
          m_read <= 1; m_addr <= pc; m_ipc <= pc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_read",       mem_read,       m_read | m_discard);
      check("mem_address",    mem_address,    m_addr);
      check("mem_byteenable", mem_byteenable, (m_read | m_discard) ? 4'hF : 4'h0);
      check("busy",           busy,           m_read | m_discard);
      check("instr_valid",    instr_valid,    m_have);
      check("instr",          instr,          m_instr);
      check("instr_pc",       instr_pc,       m_ipc);
      check("halted",         halted,         m_halted);
      check("fault",          fault,          m_fault);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] a);
    pc = a; fetch_req = 1; tick(); fetch_req = 0;
  endtask

  int busy_cnt;

  initial begin
    rst = 1; pc = 0; fetch_req = 0; stall = 0; flush = 0;
    mem_waitrequest = 0; mem_readdata = 32'h0800003C;
    tick(); tick();
    rst = 0; chk_en = 1;
    check("rst_read", mem_read, 1'b0);
    check("rst_be", mem_byteenable, 4'h0);
    check("rst_instr", instr, 32'h0);

    // Zero-wait fetch: read strobe one cycle, instr after second edge
    fetch(32'hBFC00000);
    check("a_read", mem_read, 1'b1);
    check("a_addr", mem_address, 32'hBFC00000);
    tick();
    check("a_read_off", mem_read, 1'b0);
    check("a_valid", instr_valid, 1'b1);
    check("a_instr", instr, 32'h3C000008);
    check("a_pc", instr_pc, 32'hBFC00000);
    tick();
    check("a_consumed", instr_valid, 1'b0);
    check("a_retain", instr, 32'h3C000008);

    // Three waitrequest cycles
    mem_waitrequest = 1; mem_readdata = 32'h11223344;
    fetch(32'hBFC00000);
    busy_cnt = busy;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin fetch_req = 1; pc = 32'hBFC00040; end
      tick();
      fetch_req = 0;
      busy_cnt += busy;
      check("b_addr_stable", mem_address, 32'hBFC00000);
    end
    mem_waitrequest = 0; stall = 1;
    tick();
    busy_cnt += busy;
    check("b_busy_cycles", busy_cnt, 4);
    check("b_valid", instr_valid, 1'b1);
    check("b_instr", instr, 32'h44332211);

    // Stall holds for 4 cycles, then back-to-back fetch on release
    for (int i = 0; i < 3; i++) tick();
    check("c_held", instr, 32'h44332211);
    check("c_held_v", instr_valid, 1'b1);
    stall = 0; pc = 32'hBFC00004; fetch_req = 1; mem_readdata = 32'hAABBCCDD;
    tick(); fetch_req = 0;
    check("c_read", mem_read, 1'b1);
    check("c_addr", mem_address, 32'hBFC00004);
    check("c_valid_off", instr_valid, 1'b0);
    tick();
    check("c_instr", instr, 32'hDDCCBBAA);
    tick();

    // Flush during wait -> drain
    mem_waitrequest = 1;
    fetch(32'hBFC00008);
    flush = 1; tick(); flush = 0;
    check("d_drain_read", mem_read, 1'b1);
    fetch_req = 1; pc = 32'hBFC00100; tick(); fetch_req = 0;
    check("d_drain_busy", busy, 1'b1);
    mem_waitrequest = 0; tick();
    check("d_idle_read", mem_read, 1'b0);
    check("d_no_valid", instr_valid, 1'b0);
    check("d_instr_kept", instr, 32'hDDCCBBAA);
    tick();

    // Flush on completing edge, then flush in VALID under stall with fetch_req
    fetch(32'hBFC0000C);
    flush = 1; tick(); flush = 0;
    check("e_discard", instr_valid, 1'b0);
    fetch(32'hBFC00010); tick();
    stall = 1; flush = 1; fetch_req = 1; pc = 32'hBFC00020;
    tick(); flush = 0; fetch_req = 0; stall = 0;
    check("e_flush_valid", instr_valid, 1'b0);
    check("e_flush_noread", mem_read, 1'b0);

    // Halt on pc=0, sticky, then reset; fault on misaligned
    fetch(32'h0);
    check("f_halted", halted, 1'b1);
    fetch(32'hBFC00000); tick();
    check("f_halt_noread", mem_read, 1'b0);
    rst = 1; tick(); rst = 0;
    check("f_rst_halted", halted, 1'b0);
    fetch(32'hBFC00002);
    check("f_fault", fault, 1'b1);
    check("f_fault_noread", mem_read, 1'b0);
    rst = 1; tick(); rst = 0;
    check("f_rst_fault", fault, 1'b0);
    check("f_rst_addr", mem_address, 32'h0);

    // Reset mid-REQ drops the read; late response ignored
    mem_waitrequest = 1;
    fetch(32'hBFC00200);
    rst = 1; tick(); rst = 0;
    check("g_rst_read", mem_read, 1'b0);
    mem_waitrequest = 0; tick(); tick();
    check("g_no_valid", instr_valid, 1'b0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_ifetch.md
MIPS_CPU_IFETCH -- requirements
Module: mips_cpu_ifetch

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  sync active-high reset
- pc  in  32  fetch address from PC stage
- fetch_req  in  1  request fetch of pc
- stall  in  1  decode not ready; hold instr
- flush  in  1  discard pending/held instr (redirect)
- mem_address  out  32  bus word address
- mem_read  out  1  bus read strobe
- mem_byteenable  out  4  bus byte enables
- mem_waitrequest  in  1  bus stall
- mem_readdata  in  32  bus read data, little-endian
- instr  out  32  fetched instruction, big-endian order
- instr_pc  out  32  address instr was fetched from
- instr_valid  out  1  instr holds an unconsumed instruction
- busy  out  1  fetch in flight; fetch_req ignored
- halted  out  1  fetch of address 0 requested; sticky
- fault  out  1  misaligned fetch requested; sticky

Function
REQ-003 The FSM SHALL have states IDLE, REQ, VALID, DRAIN, HALT.
REQ-004 Accept condition SHALL be fetch_req=1 and flush=0, sampled in IDLE, or in VALID together with stall=0.
REQ-005 On accept with pc[1:0]=0 and pc!=0, the block SHALL register mem_address<=pc and instr_pc<=pc, set mem_read<=1, and enter REQ.
REQ-006 On accept with pc=0, the block SHALL set halted<=1 and enter HALT; no bus read is issued.
REQ-007 On accept with pc[1:0]!=0 and pc!=0, the block SHALL set fault<=1 and enter HALT; no bus read is issued.
REQ-008 HALT SHALL be left only by rst; all inputs except rst are ignored in HALT.
REQ-009 mem_byteenable SHALL be 4'b1111 whenever mem_read=1 and 4'b0000 otherwise.
REQ-010 In REQ, mem_read and mem_address SHALL hold stable while mem_waitrequest=1.
REQ-011 In REQ, on the edge where mem_waitrequest=0 and flush=0, the block SHALL:
- set instr<={readdata[7:0],readdata[15:8],readdata[23:16],readdata[31:24]}
- set instr_valid<=1 and mem_read<=0
- enter VALID.
REQ-012 Minimum latency SHALL be 2 cycles: with fetch_req accepted at edge N and waitrequest=0, instr_valid=1 after edge N+1; each waitrequest cycle adds one.
REQ-013 In VALID, instr, instr_pc and instr_valid SHALL hold while stall=1.
REQ-014 In VALID with stall=0, the instruction SHALL be consumed at that edge:
- with an accepted fetch_req, per REQ-005..007 (back-to-back, instr_valid<=0)
- otherwise instr_valid<=0 and enter IDLE.
REQ-015 flush in VALID SHALL clear instr_valid at that edge and enter IDLE, regardless of stall or fetch_req.
REQ-016 flush in REQ with mem_waitrequest=0 SHALL discard readdata, clear mem_read, and enter IDLE with instr_valid=0.
REQ-017 flush in REQ with mem_waitrequest=1 SHALL enter DRAIN, keeping mem_read=1 (bus reads are not abortable).
REQ-018 In DRAIN, the block SHALL wait for mem_waitrequest=0, then discard the data, clear mem_read, and enter IDLE.
REQ-019 busy SHALL be 1 exactly in REQ and DRAIN; fetch_req there SHALL be ignored, not queued.
REQ-020 flush SHALL have priority over fetch_req in the same cycle; flush in IDLE or HALT SHALL have no effect.
REQ-021 instr and instr_pc SHALL retain their last values when instr_valid=0.

Reset
REQ-022 rst SHALL force state IDLE with mem_read=0, mem_address=0, mem_byteenable=0, instr=0, instr_pc=0, instr_valid=0, halted=0 and fault=0 at the next edge, in any state.
REQ-023 rst asserted mid-REQ or mid-DRAIN SHALL drop mem_read at that edge; the outstanding response SHALL be ignored.

Verification
REQ-024 Bench SHALL cover:
- pc=BFC00000, fetch_req, waitrequest=0, readdata=0x0800003C -> mem_read 1 cycle, instr=0x3C000008, instr_pc=BFC00000, instr_valid after 2 edges.
- Same fetch with waitrequest=1 for 3 cycles -> address stable, instr_valid after 5 edges, busy=1 for 4 cycles.
- instr_valid with stall=1 for 4 cycles, then stall=0 with fetch_req, pc=BFC00004 -> instr held, then next read issued on the release edge.
- flush during REQ with waitrequest=1 -> DRAIN, mem_read held until waitrequest=0, instr_valid stays 0, then IDLE.
- fetch_req with pc=0 -> halted=1, mem_read never 1; with pc=BFC00002 -> fault=1; then rst -> all outputs 0, state IDLE.
